// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: opcode map, instruction field positions and stage FSM states.
package instr_decode_stage_pkg;

   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS_LSB  = 6;
   localparam int unsigned RT_LSB  = 3;
   localparam int unsigned IMM_W   = 6;

   localparam logic [OPC_W-1:0] OP_WR_MAX = 4'h9;
   localparam logic [OPC_W-1:0] OP_STORE  = 4'hA;
   localparam logic [OPC_W-1:0] OP_BRANCH = 4'hB;
   localparam logic [OPC_W-1:0] OP_JUMP   = 4'hC;
   localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   // Only the ALU/load range 0x0-0x9 writes a destination register.
   function automatic logic writes_rd(input logic [OPC_W-1:0] op);
      logic w;
      case (op)
         OP_STORE, OP_BRANCH, OP_JUMP, OP_HALT: w = 1'b0;
         default:                               w = (op <= OP_WR_MAX);
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_decode_stage_scoreboard.sv
// Register busy scoreboard: set on issue, clear on writeback, three combinational read ports.
// Optional macro DECODE_WB_BYPASS_EN lets a same-cycle writeback clear the read result.
module decode_scoreboard #(
   parameter int unsigned REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   input  logic [REG_AW-1:0] rc_addr,
   output logic              ra_busy_c,
   output logic              rb_busy_c,
   output logic              rc_busy_c
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_view;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en) set_vec[set_addr] = 1'b1;
      if (clr_en) clr_vec[clr_addr] = 1'b1;
   end

   // A set landing this cycle is always visible so a back-to-back reader cannot slip past it.
`ifdef DECODE_WB_BYPASS_EN
   assign busy_view = (busy_q & ~clr_vec) | set_vec;
`else
   assign busy_view = busy_q | set_vec;
`endif

   assign ra_busy_c = busy_view[ra_addr];
   assign rb_busy_c = busy_view[rb_addr];
   assign rc_busy_c = busy_view[rc_addr];

   // Set wins over clear on the same bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= (busy_q & ~clr_vec) | set_vec;
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: one-entry output register with RAW hazard stall against a register scoreboard.
// Optional macro DECODE_WB_BYPASS_EN releases a stall in the writeback cycle itself.
module instr_decode_stage
   import instr_decode_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] instr,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic [REG_AW-1:0] rd,
   output logic              reg_write,
   output logic [DATA_W-1:0] imm,
   output logic [OPC_W-1:0]  opcode,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd
);

   state_e state_q;

   logic [OPC_W-1:0]  dec_op;
   logic [REG_AW-1:0] dec_rd;
   logic [REG_AW-1:0] dec_rs;
   logic [REG_AW-1:0] dec_rt;
   logic [DATA_W-1:0] dec_imm;
   logic              dec_rw;

   logic [REG_AW-1:0] chk_rs;
   logic [REG_AW-1:0] chk_rt;
   logic [REG_AW-1:0] chk_rd;
   logic              chk_rw;
   logic              rs_busy_c;
   logic              rt_busy_c;
   logic              rd_busy_c;
   logic              hazard_c;
   logic              accept_c;
   logic              consume_c;

   assign dec_op  = instr[OPC_LSB +: OPC_W];
   assign dec_rd  = instr[RD_LSB +: REG_AW];
   assign dec_rs  = instr[RS_LSB +: REG_AW];
   assign dec_rt  = instr[RT_LSB +: REG_AW];
   assign dec_imm = DATA_W'($signed(instr[IMM_W-1:0]));
   assign dec_rw  = writes_rd(dec_op);

   assign in_ready  = reset_n & ((state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_ready));
   assign accept_c  = in_valid & in_ready;
   assign consume_c = out_valid & out_ready;

   // While stalled, the held instruction is re-checked; otherwise the incoming one.
   always_comb begin
      chk_rs = dec_rs;
      chk_rt = dec_rt;
      chk_rd = dec_rd;
      chk_rw = dec_rw;
      if (state_q == ST_STALL) begin
         chk_rs = rs;
         chk_rt = rt;
         chk_rd = rd;
         chk_rw = reg_write;
      end
   end

   assign hazard_c = rs_busy_c | rt_busy_c | (chk_rw & rd_busy_c);

   decode_scoreboard #(
      .REG_AW (REG_AW)
   ) u_sb (
      .clock     (clock),
      .reset_n   (reset_n),
      .set_en    (consume_c & reg_write),
      .set_addr  (rd),
      .clr_en    (wb_valid),
      .clr_addr  (wb_rd),
      .ra_addr   (chk_rs),
      .rb_addr   (chk_rt),
      .rc_addr   (chk_rd),
      .ra_busy_c (rs_busy_c),
      .rb_busy_c (rt_busy_c),
      .rc_busy_c (rd_busy_c)
   );

   // Stage FSM and output register; out_valid mirrors the FULL state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_EMPTY;
         out_valid <= 1'b0;
         reg_write <= 1'b0;
         rs        <= '0;
         rt        <= '0;
         rd        <= '0;
         imm       <= '0;
         opcode    <= '0;
      end else begin
         case (state_q)
            ST_EMPTY, ST_FULL: begin
               if (accept_c) begin
                  opcode    <= dec_op;
                  rd        <= dec_rd;
                  rs        <= dec_rs;
                  rt        <= dec_rt;
                  imm       <= dec_imm;
                  reg_write <= dec_rw;
                  state_q   <= hazard_c ? ST_STALL : ST_FULL;
                  out_valid <= ~hazard_c;
               end else if (consume_c) begin
                  state_q   <= ST_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ST_STALL: begin
               if (!hazard_c) begin
                  state_q   <= ST_FULL;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard-style bench for instr_decode_stage; expectations follow DECODE_WB_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_instr_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
   localparam int WB_TO_VALID = 1;
`else
   localparam int WB_TO_VALID = 2;
`endif

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [15:0] imm;
      logic        rw;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instr;
   logic [2:0]  rs, rt, rd;
   logic        reg_write;
   logic [15:0] imm;
   logic [3:0]  opcode;
   logic        out_valid;
   logic        out_ready;
   logic        wb_valid;
   logic [2:0]  wb_rd;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   consume_cnt = 0;
   int   consume_cyc = 0;
   exp_t exp_q[$];

   instr_decode_stage #(.DATA_W(16), .REG_AW(3)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .reg_write (reg_write),
      .imm       (imm),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s,
                               input logic [2:0] t, input logic [15:0] im, input logic w);
      exp_t e;
      e.op = op; e.rd = d; e.rs = s; e.rt = t; e.imm = im; e.rw = w;
      return e;
   endfunction

   // Monitor: every downstream consume is compared against the oldest expectation.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && out_valid && out_ready) begin
         consume_cnt++;
         consume_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got opcode 0x%0h rd %0d, required no output", opcode, rd);
         end else begin
            e = exp_q.pop_front();
            check("opcode",    32'(opcode),    32'(e.op));
            check("rd",        32'(rd),        32'(e.rd));
            check("rs",        32'(rs),        32'(e.rs));
            check("rt",        32'(rt),        32'(e.rt));
            check("imm",       32'(imm),       32'(e.imm));
            check("reg_write", 32'(reg_write), 32'(e.rw));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      logic rdy;
      int   n;
      in_valid = 1'b1;
      instr    = w;
      rdy      = 1'b0;
      n        = 0;
      while (!rdy && n < 50) begin
         @(negedge clock);
         rdy = in_ready;
         @(posedge clock);
         n++;
      end
      #1;
      in_valid = 1'b0;
      if (!rdy) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: instr 0x%0h not accepted in %0d cycles, required acceptance", w, n);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      tick();
      check("drain_queue_empty", 32'(exp_q.size()), 0);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      wb_valid = 1'b0;
      @(negedge clock);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready",  32'(in_ready),  0);
      check("rst_reg_write", 32'(reg_write), 0);
      check("rst_opcode",    32'(opcode),    0);
      check("rst_regs",      32'({rd, rs, rt}), 0);
      check("rst_imm",       32'(imm),       0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_in_ready",  32'(in_ready),  1);
      check("post_rst_out_valid", 32'(out_valid), 0);
      check("post_rst_scoreboard", 32'(dut.u_sb.busy_q), 0);
      tick();
   endtask

   task automatic expect_stalled(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(negedge clock);
         check({name, "_out_valid"}, 32'(out_valid), 0);
         check({name, "_in_ready"},  32'(in_ready),  0);
         tick();
      end
   endtask

   logic [15:0] tp_vec [8];
   int          c0;
   int          a0;
   int          lat;

   initial begin
      in_valid  = 1'b0;
      instr     = '0;
      out_ready = 1'b0;
      wb_valid  = 1'b0;
      wb_rd     = '0;
      tp_vec    = '{16'h11F8, 16'h13F8, 16'h15F8, 16'h17F8, 16'h19F8, 16'h1BF8, 16'h1DF8, 16'h1FF8};
      do_reset();

      // Field decode, sign extension and reg_write at the 0x9/0xA boundary.
      out_ready = 1'b1;
      exp_q.push_back(mk(4'h1, 3'd5, 3'd0, 3'd7, 16'hFFFD, 1'b1));
      send(16'h1A3D);
      check("latency_out_valid", 32'(out_valid), 1);
      exp_q.push_back(mk(4'hA, 3'd0, 3'd3, 3'd0, 16'h0001, 1'b0));
      send(16'hA0C1);
      exp_q.push_back(mk(4'h9, 3'd7, 3'd1, 3'd7, 16'hFFFF, 1'b1));
      send(16'h9E7F);
      exp_q.push_back(mk(4'hF, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0));
      send(16'hF000);
      wait_drain();
      check("sb_after_decode", 32'(dut.u_sb.busy_q), 32'h0000_00A0);

      // RAW stall on r1 released by writeback.
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(mk(4'h1, 3'd1, 3'd0, 3'd0, 16'h0000, 1'b1));
      send(16'h1200);
      exp_q.push_back(mk(4'h2, 3'd0, 3'd1, 3'd0, 16'h0000, 1'b1));
      send(16'h2040);
      expect_stalled("raw_stall", 4);
      wb_valid = 1'b1;
      wb_rd    = 3'd1;
      @(negedge clock);
      check("wb_cycle_out_valid", 32'(out_valid), 0);
      tick();
      wb_valid = 1'b0;
      lat = 0;
      for (int k = 1; k < 10; k++) begin
         @(negedge clock);
         if (out_valid) begin
            lat = k;
            break;
         end
         tick();
      end
      tick();
      check("wb_to_out_valid_cycles", 32'(lat), 32'(WB_TO_VALID));
      wait_drain();
      check("sb_after_raw", 32'(dut.u_sb.busy_q), 32'h0000_0001);

      // Backpressure: output held stable, nothing lost or duplicated.
      do_reset();
      out_ready = 1'b0;
      c0 = consume_cnt;
      exp_q.push_back(mk(4'h3, 3'd5, 3'd2, 3'd1, 16'h000F, 1'b1));
      send(16'h3A8F);
      check("bp_out_valid_first", 32'(out_valid), 1);
      in_valid = 1'b1;
      instr    = 16'h4000;
      exp_q.push_back(mk(4'h4, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1));
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("bp_out_valid", 32'(out_valid), 1);
         check("bp_in_ready",  32'(in_ready),  0);
         check("bp_fields",    32'({opcode, rd, rs, rt, reg_write}), 32'({4'h3, 3'd5, 3'd2, 3'd1, 1'b1}));
         check("bp_imm",       32'(imm), 32'h0000_000F);
         tick();
      end
      out_ready = 1'b1;
      send(16'h4000);
      wait_drain();
      check("bp_consume_count", 32'(consume_cnt - c0), 2);

      // Same-cycle set and clear of r2 leaves it busy.
      do_reset();
      out_ready = 1'b1;
      exp_q.push_back(mk(4'h1, 3'd2, 3'd0, 3'd0, 16'h0000, 1'b1));
      send(16'h1400);
      wb_valid = 1'b1;
      wb_rd    = 3'd2;
      tick();
      wb_valid = 1'b0;
      check("sb_set_wins", 32'(dut.u_sb.busy_q), 32'h0000_0004);
      exp_q.push_back(mk(4'h2, 3'd0, 3'd2, 3'd0, 16'h0000, 1'b1));
      send(16'h2080);
      expect_stalled("r2_stall", 3);
      wb_valid = 1'b1;
      wb_rd    = 3'd2;
      tick();
      wb_valid = 1'b0;
      wait_drain();

      // Throughput: eight independent writes back to back, then a reader of r0 stalls.
      do_reset();
      out_ready = 1'b1;
      c0 = consume_cnt;
      a0 = 0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(4'h1, 3'(i), 3'd7, 3'd7, 16'hFFF8, 1'b1));
         send(tp_vec[i]);
         if (i == 0) a0 = cyc;
      end
      send(16'h2000);
      check("tp_consume_count", 32'(consume_cnt - c0), 8);
      check("tp_last_consume_cycle", 32'(consume_cyc), 32'(a0 + 7));
      check("tp_sb_all_busy", 32'(dut.u_sb.busy_q), 32'h0000_00FF);
      expect_stalled("tp_r0_stall", 3);

      // Reset mid-STALL discards the held instruction.
      c0 = consume_cnt;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("post_stall_rst_out_valid", 32'(out_valid), 0);
         tick();
      end
      check("post_stall_rst_consumes", 32'(consume_cnt - c0), 0);

      // Reset mid-FULL discards the held instruction.
      out_ready = 1'b0;
      send(16'h5000);
      check("full_before_rst", 32'(out_valid), 1);
      do_reset();
      out_ready = 1'b1;
      c0 = consume_cnt;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("post_full_rst_out_valid", 32'(out_valid), 0);
         tick();
      end
      check("post_full_rst_consumes", 32'(consume_cnt - c0), 0);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction and immediate width.
REQ-002 SHALL have parameter REG_AW, default 3, register address width (8 registers).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 SHALL have port instr  input  DATA_W  instruction word.
REQ-008 SHALL have ports rs, rt, rd  output  REG_AW each  register-bank addresses.
REQ-009 SHALL have port reg_write  output  1  decoded instruction writes rd.
REQ-010 SHALL have port imm  output  DATA_W  sign-extended instr[5:0].
REQ-011 SHALL have port opcode  output  4  instr[15:12].
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1  downstream handshake.
REQ-013 SHALL have ports wb_valid input 1 and wb_rd input REG_AW  writeback retire notification.

Function
REQ-014 SHALL decode fields: opcode=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm=sext([5:0]).
REQ-015 SHALL set reg_write=1 for opcodes 0x0-0x9; 0 otherwise (0xA store, 0xB branch, 0xC jump, 0xF halt, others nop).
REQ-016 SHALL hold a one-entry output register; transfer occurs on in_valid && in_ready, output consumed on out_valid && out_ready.
REQ-017 SHALL have FSM states EMPTY, FULL, STALL.
REQ-018 EMPTY: in_ready=1, out_valid=0; accepted instruction -> FULL if hazard-free, else STALL.
REQ-019 FULL: out_valid=1; on consume with simultaneous accept -> FULL/STALL per new instruction; consume alone -> EMPTY; no consume -> stay, in_ready=0.
REQ-020 STALL: out_valid=0, in_ready=0; re-evaluate each cycle; -> FULL when hazard clears.
REQ-021 SHALL keep an 8-bit scoreboard; bit rd set when an instruction with reg_write=1 is consumed downstream.
REQ-022 SHALL clear scoreboard bit wb_rd when wb_valid=1; set and clear of the same bit in one cycle SHALL leave it set.
REQ-023 Hazard SHALL be scoreboard[rs] | scoreboard[rt] | (reg_write & scoreboard[rd]); register 0 is not special.
REQ-024 Latency: instruction accepted in cycle N with no hazard SHALL present out_valid in cycle N+1.
REQ-025 Outputs rs/rt/rd/imm/opcode/reg_write SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Outputs SHALL change only on posedge clock, so the register bank samples addresses at the following posedge and writeback lands on negedge.

Reset
REQ-027 reset_n=0 SHALL immediately force state EMPTY, scoreboard=0, out_valid=0, reg_write=0, rs=rt=rd=0, imm=0, opcode=0.
REQ-028 in_ready SHALL be 0 while reset_n=0 and 1 in the first cycle after release.
REQ-029 Reset mid-STALL or mid-FULL SHALL discard the held instruction with no partial output.

Configuration
REQ-030 Macro DECODE_WB_BYPASS_EN: when defined, a wb_valid for a register SHALL clear that register's hazard in the same cycle, giving STALL -> FULL one cycle earlier.
REQ-031 Without DECODE_WB_BYPASS_EN, the hazard check SHALL use only the registered scoreboard, giving minimum stall = wb cycle + 1.

Structure
REQ-032 A shared package SHALL hold the opcode constants, field bit positions, and the FSM state enum.
REQ-033 Scoreboard SHALL be a sub-module named decode_scoreboard (set, clear, three read ports, bypass option).

Verification
REQ-034 Reset: hold reset_n=0 mid-operation -> out_valid=0, scoreboard=0, in_ready=1 in the first cycle after release.
REQ-035 Decode: instr=0x1A3D, out_ready=1 -> one cycle later opcode=1, rd=5, rs=0, rt=7, imm=0xFFFD, reg_write=1.
REQ-036 RAW stall: issue 0x1200 (rd=1), then 0x2040 (rs=1) -> STALL until wb_valid with wb_rd=1; FULL one cycle later without the macro, same cycle with it.
REQ-037 Backpressure: out_ready=0 for 3 cycles in FULL -> in_ready=0, outputs unchanged, nothing lost or duplicated.
REQ-038 Same-cycle set/clear: consume a write to r2 while wb_valid with wb_rd=2 -> scoreboard[2]=1.
REQ-039 Throughput: 8 independent writes to r0-r7 with out_ready=1 -> 8 outputs in 8 consecutive cycles, and the 9th instruction reading r0 stalls.
